csr_counter_bank: RTL and testbench

//  Parametrised bank of RISC-V counter CSRs: cycle, time, instret and N_EVENT

---
 rtl/csr_counter_bank.sv | 125 ++++++++++++
 tb/tb_csr_counter_bank.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_counter_bank.sv
// RISC-V counter CSR bank: cycle, time, instret and hpm event counters with
// mcountinhibit, a time prescaler, M-mode writes and a registered response.
module csr_counter_bank #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CNT_WIDTH = 64,
  parameter int unsigned N_EVENT   = 4,
  parameter int unsigned TIME_DIV  = 1
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [11:0]        csr_addr_i,
  input  logic               csr_rd_en_i,
  input  logic               csr_wr_en_i,
  input  logic [XLEN-1:0]    csr_wr_data_i,
  input  logic               instr_retired_i,
  input  logic [N_EVENT-1:0] event_i,
  output logic [XLEN-1:0]    csr_rd_data_o,
  output logic               csr_rd_valid_o,
  output logic               csr_illegal_o
);

  localparam int unsigned NC = N_EVENT + 3;
  localparam int unsigned HW = CNT_WIDTH - XLEN;
  localparam int unsigned PW = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TIME_DIV - 1);

  logic [CNT_WIDTH-1:0] cnt_q [NC];
  logic [CNT_WIDTH-1:0] cnt_d [NC];
  logic [NC-1:0]        inh_q, inh_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [XLEN-1:0]      rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 illegal_q, illegal_d;

  logic [6:0]           region;
  logic [4:0]           idx;
  logic                 hi_half, idx_ok, hit_user, hit_mach, hit_inh;
  logic                 req, legal, wr_cnt, wr_inh, tick;
  logic [CNT_WIDTH-1:0] cnt_sel;
  logic [XLEN-1:0]      rd_val;
  logic [NC-1:0]        inc;

  // addr[11:5] picks the 32-entry window (C00/C80/B00/B80), addr[4:0] the counter
  assign region   = csr_addr_i[11:5];
  assign idx      = csr_addr_i[4:0];
  assign hi_half  = csr_addr_i[7];
  assign idx_ok   = 32'(idx) < NC;
  assign hit_user = idx_ok && (region == 7'h60 || region == 7'h64);
  assign hit_mach = idx_ok && (idx != 5'd1) && (region == 7'h58 || region == 7'h5C);
  assign hit_inh  = (csr_addr_i == 12'h320);
  assign req      = csr_rd_en_i || csr_wr_en_i;
  assign legal    = req && (hit_mach || hit_inh || (hit_user && !csr_wr_en_i));
  assign wr_cnt   = legal && csr_wr_en_i && hit_mach;
  assign wr_inh   = legal && csr_wr_en_i && hit_inh;
  assign tick     = (presc_q == PRESC_LAST);

  always_comb begin
    cnt_sel = '0;
    for (int unsigned k = 0; k < NC; k++) begin
      if (32'(idx) == k) cnt_sel = cnt_q[k];
    end
    if (hit_inh)      rd_val = XLEN'(inh_q);
    else if (hi_half) rd_val = XLEN'(cnt_sel >> XLEN);
    else              rd_val = cnt_sel[XLEN-1:0];
  end

  // Time ignores mcountinhibit; the rest honour their inhibit bit
  always_comb begin
    inc    = '0;
    inc[0] = !inh_q[0];
    inc[1] = tick;
    inc[2] = instr_retired_i && !inh_q[2];
    for (int unsigned k = 0; k < N_EVENT; k++) begin
      inc[k+3] = event_i[k] && !inh_q[k+3];
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NC; k++) begin
      cnt_d[k] = cnt_q[k];
      if (wr_cnt && 32'(idx) == k) begin
        if (hi_half) cnt_d[k][CNT_WIDTH-1:XLEN] = csr_wr_data_i[HW-1:0];
        else         cnt_d[k][XLEN-1:0]         = csr_wr_data_i;
      end else if (inc[k]) begin
        cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    inh_d = inh_q;
    if (wr_inh) begin
      inh_d    = csr_wr_data_i[NC-1:0];
      inh_d[1] = 1'b0;
    end
    presc_d    = tick ? '0 : presc_q + PW'(1);
    rd_valid_d = req;
    illegal_d  = req && !legal;
    rd_data_d  = rd_data_q;
    if (req) rd_data_d = legal ? rd_val : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int unsigned k = 0; k < NC; k++) cnt_q[k] <= '0;
      inh_q      <= '0;
      presc_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NC; k++) cnt_q[k] <= cnt_d[k];
      inh_q      <= inh_d;
      presc_q    <= presc_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      illegal_q  <= illegal_d;
    end
  end

  assign csr_rd_data_o  = rd_data_q;
  assign csr_rd_valid_o = rd_valid_q;
  assign csr_illegal_o  = illegal_q;

endmodule

// File: tb/tb_csr_counter_bank.sv
// Self-checking bench for csr_counter_bank: directed scenarios plus random
// traffic compared every cycle against an array-based reference model.
module tb_csr_counter_bank;

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 64;
  localparam int unsigned NE   = 4;
  localparam int unsigned TD   = 4;
  localparam int unsigned NC   = NE + 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [11:0]     addr = '0;
  logic            rd = 1'b0, wr = 1'b0;
  logic [XLEN-1:0] wdata = '0;
  logic            instr = 1'b0;
  logic [NE-1:0]   ev = '0;
  logic [XLEN-1:0] rdata;
  logic            rvalid, rill;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_counter_bank #(
    .XLEN(XLEN), .CNT_WIDTH(CW), .N_EVENT(NE), .TIME_DIV(TD)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .csr_addr_i(addr), .csr_rd_en_i(rd),
    .csr_wr_en_i(wr), .csr_wr_data_i(wdata), .instr_retired_i(instr),
    .event_i(ev), .csr_rd_data_o(rdata), .csr_rd_valid_o(rvalid),
    .csr_illegal_o(rill)
  );

  // reference state
  bit [63:0]   m_cnt [NC];
  int unsigned m_presc;
  bit [31:0]   m_inh;
  bit          e_valid, e_ill, e_known;
  bit [31:0]   e_data;

  function automatic void decode(input int a, input bit w, output int kind,
                                 output int k, output bit hi, output bit ok);
    kind = 0; k = 0; hi = 0; ok = 0;
    if (a >= 'hC00 && a < 'hC00 + NC) begin kind = 1; k = a - 'hC00; ok = !w; end
    else if (a >= 'hC80 && a < 'hC80 + NC) begin kind = 1; k = a - 'hC80; hi = 1; ok = !w; end
    else if (a >= 'hB00 && a < 'hB00 + NC && a != 'hB01) begin kind = 1; k = a - 'hB00; ok = 1; end
    else if (a >= 'hB80 && a < 'hB80 + NC && a != 'hB81) begin kind = 1; k = a - 'hB80; hi = 1; ok = 1; end
    else if (a == 'h320) begin kind = 2; ok = 1; end
  endfunction

  task automatic model_edge();
    int kind, k;
    bit hi, ok, req;
    bit [31:0] old, mask;
    bit [63:0] nxt [NC];
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) m_cnt[i] = '0;
      m_presc = 0; m_inh = '0;
      e_valid = 0; e_ill = 0; e_data = '0; e_known = 1;
      return;
    end
    req = rd || wr;
    decode(int'(addr), wr, kind, k, hi, ok);
    old = 0;
    if (kind == 1) old = hi ? m_cnt[k][63:32] : m_cnt[k][31:0];
    else if (kind == 2) old = m_inh;
    for (int i = 0; i < NC; i++) nxt[i] = m_cnt[i];
    if (!m_inh[0]) nxt[0] = m_cnt[0] + 1;
    if (m_presc == TD - 1) nxt[1] = m_cnt[1] + 1;
    if (instr && !m_inh[2]) nxt[2] = m_cnt[2] + 1;
    for (int i = 3; i < NC; i++) if (ev[i-3] && !m_inh[i]) nxt[i] = m_cnt[i] + 1;
    mask = ((32'd1 << NC) - 1) & ~32'd2;
    if (req && ok && wr) begin
      if (kind == 1) nxt[k] = hi ? {wdata, m_cnt[k][31:0]} : {m_cnt[k][63:32], wdata};
      else m_inh = wdata & mask;
    end
    for (int i = 0; i < NC; i++) m_cnt[i] = nxt[i];
    m_presc = (m_presc + 1) % TD;
    e_valid = req;
    e_ill   = req && !ok;
    if (req) begin
      if (!ok)    begin e_data = '0;  e_known = 1; end
      else if (rd) begin e_data = old; e_known = 1; end
      else        e_known = 0;
    end
  endtask

  task automatic check();
    checks++;
    assert (rvalid === e_valid) else begin
      errors++; $error("FAIL valid obs=%0b exp=%0b addr=%h", rvalid, e_valid, addr);
    end
    checks++;
    assert (rill === e_ill) else begin
      errors++; $error("FAIL illegal obs=%0b exp=%0b addr=%h", rill, e_ill, addr);
    end
    if (e_known) begin
      checks++;
      assert (rdata === e_data) else begin
        errors++; $error("FAIL rdata obs=%h exp=%h addr=%h", rdata, e_data, addr);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic access(input bit r, input bit w, input int a, input bit [31:0] d);
    rd = r; wr = w; addr = 12'(a); wdata = d;
    tick();
    rd = 0; wr = 0;
  endtask

  task automatic expect_data(input string tag, input bit [31:0] v);
    checks++;
    assert (rvalid === 1'b1 && rill === 1'b0 && rdata === v) else begin
      errors++;
      $error("FAIL %s obs=%h/v%0b/i%0b exp=%h/v1/i0", tag, rdata, rvalid, rill, v);
    end
  endtask

  task automatic expect_illegal(input string tag);
    checks++;
    assert (rvalid === 1'b1 && rill === 1'b1 && rdata === 32'h0) else begin
      errors++;
      $error("FAIL %s obs=%h/v%0b/i%0b exp=0/v1/i1", tag, rdata, rvalid, rill);
    end
  endtask

  task automatic do_reset();
    rst_n = 0; rd = 0; wr = 0; instr = 0; ev = '0;
    tick(); tick();
    rst_n = 1;
  endtask

  function automatic int rand_addr();
    int u;
    u = int'($urandom_range(0, 7));
    case ($urandom_range(0, 5))
      0: return 'hC00 + u;
      1: return 'hC80 + u;
      2: return 'hB00 + u;
      3: return 'hB80 + u;
      4: return ($urandom_range(0, 3) == 0) ? 'h321 : 'h320;
      default: return int'($urandom_range(0, 4095));
    endcase
  endfunction

  initial begin
    // reset state and cycle count from release
    do_reset();
    checks++;
    assert (rvalid === 1'b0 && rill === 1'b0 && rdata === 32'h0) else begin
      errors++; $error("FAIL reset_out obs=%h/v%0b/i%0b exp=0/v0/i0", rdata, rvalid, rill);
    end
    idle(10);
    access(1, 0, 'hC00, 0);
    expect_data("cycle10", 32'd10);
    tick();
    checks++;
    assert (rvalid === 1'b0) else begin
      errors++; $error("FAIL valid_pulse obs=%0b exp=0", rvalid);
    end

    // prescaled time and read-only user space
    do_reset();
    idle(16);
    access(1, 0, 'hC01, 0);
    expect_data("time4", 32'd4);
    access(0, 1, 'hC01, 32'h1234);
    expect_illegal("wr_user_time");
    access(1, 1, 'hB01, 32'h1);
    expect_illegal("wr_mtime");

    // low-to-high carry
    access(0, 1, 'hB00, 32'hFFFF_FFFF);
    access(0, 1, 'hB80, 32'h0);
    idle(1);
    access(1, 0, 'hC00, 0);
    expect_data("carry_lo", 32'h0);
    access(1, 0, 'hC80, 0);
    expect_data("carry_hi", 32'h1);

    // inhibit instret
    do_reset();
    access(0, 1, 'h320, 32'h4);
    for (int i = 0; i < 5; i++) begin instr = 1; tick(); instr = 0; tick(); end
    access(1, 0, 'hC02, 0);
    expect_data("instret_inh", 32'd0);
    access(0, 1, 'h320, 32'h0);
    for (int i = 0; i < 5; i++) begin instr = 1; tick(); instr = 0; tick(); end
    access(1, 0, 'hC02, 0);
    expect_data("instret5", 32'd5);
    access(1, 0, 'h320, 0);
    expect_data("inh_rd", 32'd0);
    access(1, 1, 'h320, 32'hFFFF_FFFF);
    access(1, 0, 'h320, 0);
    expect_data("inh_mask", 32'h7D);
    access(0, 1, 'h320, 32'h0);

    // CSRRW on hpm3
    access(0, 1, 'hB03, 32'd7);
    access(1, 1, 'hB03, 32'h55);
    expect_data("csrrw_old", 32'd7);
    access(1, 0, 'hC03, 0);
    expect_data("csrrw_new", 32'h55);

    // unmapped address
    access(1, 0, 'hC1F, 0);
    expect_illegal("unmapped_C1F");
    access(1, 0, 'hC07, 0);
    expect_illegal("unmapped_C07");

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      rd    = ($urandom_range(0, 2) == 0);
      wr    = ($urandom_range(0, 3) == 0);
      addr  = 12'(rand_addr());
      case ($urandom_range(0, 3))
        0: wdata = 32'hFFFF_FFFF;
        1: wdata = 32'hFFFF_FFFE;
        default: wdata = $urandom;
      endcase
      instr = $urandom_range(0, 1) == 1;
      ev    = NE'($urandom);
      tick();
    end
    rst_n = 1; rd = 0; wr = 0; instr = 0; ev = '0;
    tick();

    // reset with a response pending
    access(1, 0, 'hC00, 0);
    rst_n = 0;
    tick();
    checks++;
    assert (rvalid === 1'b0 && rill === 1'b0 && rdata === 32'h0) else begin
      errors++; $error("FAIL reset_drop obs=%h/v%0b/i%0b exp=0/v0/i0", rdata, rvalid, rill);
    end
    rst_n = 1;
    access(1, 0, 'hC00, 0);
    expect_data("post_rst_cycle", 32'd0);
    access(1, 0, 'hC83, 0);
    expect_data("post_rst_hpm3h", 32'd0);
    access(1, 0, 'h320, 0);
    expect_data("post_rst_inh", 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
